// File: rtl/ofm_wb_pkg.sv
// Shared types for the OFM writeback path: FSM state and the FIFO entry
// that carries a word address together with its int8 vector.
package ofm_wb_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = LANES * 8;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and full/empty flags.
// Push while full is legal only together with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt == CNT_W'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/ofm_writeback16.sv
// Buffers requantized OFM vectors and writes them to SRAM in pixel-major order,
// raising in_stall early because the producer cannot be back-pressured.
module ofm_writeback16
  import ofm_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned STALL_MARGIN = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_pix,
  input  logic [CNT_W-1:0]  cfg_num_ctile,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_stall,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_unexpected
);

  localparam int unsigned FC_W  = $clog2(DEPTH) + 1;
  localparam int unsigned REM_W = 2 * CNT_W;

  wb_state_t         state;
  logic [CNT_W-1:0]  num_pix_q;
  logic [CNT_W-1:0]  num_ctile_q;
  logic [CNT_W-1:0]  pix_q;
  logic [REM_W-1:0]  rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base_q;

  logic [FC_W-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  wb_entry_t       wr_entry;
  wb_entry_t       head;

  logic            accept_ok;
  logic            push;
  logic            pop;
  logic            ovf_hit;
  logic            unexp_hit;
  logic [FC_W-1:0] cnt_nxt;
  logic            stall_cnt;
  logic            cfg_zero;

  assign mem_wr_valid = !fifo_empty;
  assign mem_wr_addr  = head.addr;
  assign mem_wr_data  = head.data;

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign accept_ok = (state == ST_RUN) && (rem_q != '0);
  assign pop       = mem_wr_valid && mem_wr_ready;
  assign push      = in_valid && accept_ok && (!fifo_full || pop);
  assign ovf_hit   = in_valid && accept_ok && fifo_full && !pop;
  assign unexp_hit = in_valid && !accept_ok;
  assign cnt_nxt   = fifo_count + FC_W'(push) - FC_W'(pop);
  assign stall_cnt = (FC_W'(DEPTH) - cnt_nxt) <= FC_W'(STALL_MARGIN);
  assign cfg_zero  = (cfg_num_pix == '0) || (cfg_num_ctile == '0);

  assign wr_entry.addr = addr_q;
  assign wr_entry.data = in_data;

  sync_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job FSM plus incremental address generation (advances on push).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      num_pix_q      <= '0;
      num_ctile_q    <= '0;
      pix_q          <= '0;
      rem_q          <= '0;
      addr_q         <= '0;
      row_base_q     <= '0;
      in_stall       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ovf_hit)   err_overflow   <= 1'b1;
      if (unexp_hit) err_unexpected <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          in_stall <= 1'b1;
          busy     <= 1'b0;
          if (cfg_start) begin
            if (cfg_zero) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state       <= ST_RUN;
              busy        <= 1'b1;
              in_stall    <= stall_cnt;
              num_pix_q   <= cfg_num_pix;
              num_ctile_q <= cfg_num_ctile;
              rem_q       <= REM_W'(cfg_num_pix) * REM_W'(cfg_num_ctile);
              pix_q       <= '0;
              addr_q      <= cfg_base_addr;
              row_base_q  <= cfg_base_addr;
            end
          end
        end
        ST_RUN: begin
          busy     <= 1'b1;
          in_stall <= stall_cnt;
          if (push) begin
            rem_q <= rem_q - REM_W'(1);
            if (pix_q == num_pix_q - CNT_W'(1)) begin
              pix_q      <= '0;
              row_base_q <= row_base_q + ADDR_W'(1);
              addr_q     <= row_base_q + ADDR_W'(1);
            end else begin
              pix_q  <= pix_q + CNT_W'(1);
              addr_q <= addr_q + ADDR_W'(num_ctile_q);
            end
            if (rem_q == REM_W'(1)) begin
              state    <= ST_DRAIN;
              in_stall <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          in_stall <= 1'b1;
          busy     <= 1'b1;
          if (fifo_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          in_stall <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writeback16.sv
// Scoreboard bench for ofm_writeback16: expected {addr,data} words are queued
// at stimulus time and compared as the SRAM port handshakes.
module tb_ofm_writeback16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [15:0]  cfg_base_addr;
  logic [15:0]  cfg_num_pix;
  logic [15:0]  cfg_num_ctile;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_stall;
  logic         mem_wr_valid;
  logic [15:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic         mem_wr_ready;
  logic         busy;
  logic         done;
  logic         err_overflow;
  logic         err_unexpected;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  logic [143:0] sb [$];
  int m_base, m_np, m_nc, m_p, m_ct;

  always #5 clk = ~clk;

  ofm_writeback16 dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_pix    (cfg_num_pix),
    .cfg_num_ctile  (cfg_num_ctile),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_stall       (in_stall),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ready   (mem_wr_ready),
    .busy           (busy),
    .done           (done),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected)
  );

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int base, input int np, input int nc);
    m_base = base; m_np = np; m_nc = nc; m_p = 0; m_ct = 0;
    cfg_base_addr = 16'(base);
    cfg_num_pix   = 16'(np);
    cfg_num_ctile = 16'(nc);
    cfg_start     = 1'b1;
    cyc();
    cfg_start     = 1'b0;
  endtask

  // Drive one vector; if it should be accepted, queue its pixel-major address.
  task automatic send(input bit acc);
    logic [127:0] d;
    logic [15:0]  a;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1;
    in_data  = d;
    if (acc) begin
      a = 16'(m_base + m_p * m_nc + m_ct);
      sb.push_back({a, d});
      m_p++;
      if (m_p == m_np) begin
        m_p = 0;
        m_ct++;
      end
    end
    cyc();
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", done, 1);
    cyc();
  endtask

  task automatic wait_sb_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
    chk("sb_drained", 144'(sb.size()), 0);
  endtask

  // Monitor: inputs only change just after posedge, so negedge sees the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_valid && mem_wr_ready) begin
        wr_cnt++;
        if (sb.size() != 0) chk("wr_word", {mem_wr_addr, mem_wr_data}, sb.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int w0, d0;
    logic [143:0] hd;
    rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_pix = '0;
    cfg_num_ctile = '0; in_valid = 1'b0; in_data = '0; mem_wr_ready = 1'b0;

    // Reset values
    cyc();
    chk("rst_stall", in_stall, 0);
    chk("rst_valid", mem_wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_overflow, err_unexpected}, 0);
    chk("rst_addr_data", {mem_wr_addr, mem_wr_data}, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("idle_stall", in_stall, 1);

    // Base address: pixel-major order with back-to-back input
    mem_wr_ready = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    start(32'h100, 3, 2);
    chk("run_busy", busy, 1);
    for (int i = 0; i < 6; i++) send(1'b1);
    in_valid = 1'b0;
    wait_done(40);
    chk("t1_writes", 144'(wr_cnt - w0), 6);
    chk("t1_done_once", 144'(done_cnt - d0), 1);
    chk("t1_sb_empty", 144'(sb.size()), 0);

    // Stall and hold
    mem_wr_ready = 1'b0;
    w0 = wr_cnt;
    start(0, 16, 1);
    for (int i = 0; i < 8; i++) begin
      send(1'b1);
      if (i == 3) chk("stall_at4", in_stall, 0);
      if (i == 4) chk("stall_at5", in_stall, 1);
    end
    in_valid = 1'b0;
    chk("t2_no_ovf", err_overflow, 0);
    chk("t2_valid", mem_wr_valid, 1);
    hd = sb[0];
    chk("t2_head", {mem_wr_addr, mem_wr_data}, hd);
    cyc(); cyc(); cyc();
    chk("t2_head_hold", {mem_wr_addr, mem_wr_data}, hd);
    chk("t2_stall_full", in_stall, 1);
    mem_wr_ready = 1'b1;
    wait_sb_empty(30);
    chk("t2_drained8", 144'(wr_cnt - w0), 8);
    for (int i = 0; i < 8; i++) send(1'b1);
    in_valid = 1'b0;
    wait_done(40);
    chk("t2_writes", 144'(wr_cnt - w0), 16);

    // Overflow: simultaneous push/pop when full is fine, push without pop drops
    mem_wr_ready = 1'b0;
    w0 = wr_cnt;
    start(32'h200, 16, 1);
    for (int i = 0; i < 8; i++) send(1'b1);
    mem_wr_ready = 1'b1;
    send(1'b1);
    mem_wr_ready = 1'b0;
    chk("t3_full_pushpop_ok", err_overflow, 0);
    send(1'b0);
    in_valid = 1'b0;
    chk("t3_ovf", err_overflow, 1);
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(1'b1);
    in_valid = 1'b0;
    wait_done(40);
    chk("t3_writes", 144'(wr_cnt - w0), 16);
    chk("t3_ovf_sticky", err_overflow, 1);

    // Degenerate config and input while idle
    w0 = wr_cnt;
    chk("t4_no_unexp_yet", err_unexpected, 0);
    start(32'h50, 4, 0);
    chk("t4_done_next", done, 1);
    cyc();
    chk("t4_done_pulse", done, 0);
    send(1'b0);
    in_valid = 1'b0;
    chk("t4_unexp", err_unexpected, 1);
    cyc();
    chk("t4_no_writes", 144'(wr_cnt - w0), 0);

    // Address wrap modulo 2^16
    w0 = wr_cnt;
    start(32'hFFFE, 2, 2);
    for (int i = 0; i < 4; i++) send(1'b1);
    in_valid = 1'b0;
    wait_done(40);
    chk("t5_writes", 144'(wr_cnt - w0), 4);

    // Reset mid-run, then a fresh job
    mem_wr_ready = 1'b0;
    start(32'h300, 8, 2);
    for (int i = 0; i < 3; i++) send(1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    sb.delete();
    chk("t6_valid", mem_wr_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_errs", {err_overflow, err_unexpected}, 0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("t6_idle_valid", mem_wr_valid, 0);
    mem_wr_ready = 1'b1;
    w0 = wr_cnt;
    start(32'h10, 2, 3);
    for (int i = 0; i < 6; i++) send(1'b1);
    in_valid = 1'b0;
    wait_done(40);
    chk("t6_writes", 144'(wr_cnt - w0), 6);
    chk("t6_sb_empty", 144'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
